// File: rtl/mp_pkg.sv
// ============================================================================
// Module   : mp_pkg
// Purpose  : Shared definitions for the main-processor result FIFO: register
//            offsets of the slave port, bus/result widths and a helper that
//            packs the STATUS register word.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mp_pkg;

  // Result and slave bus widths
  localparam int MP_RES_W  = 64;
  localparam int MP_BUS_AW = 16;
  localparam int MP_BUS_DW = 32;

  // Register offsets (only s_addr[3:0] is decoded)
  localparam logic [3:0] MP_RF_DATA   = 4'h0;
  localparam logic [3:0] MP_RF_STATUS = 4'h1;
  localparam logic [3:0] MP_RF_INT_EN = 4'h2;
  localparam logic [3:0] MP_RF_CTRL   = 4'h3;
  localparam logic [3:0] MP_RF_THRESH = 4'h4;

  // STATUS layout: {50'b0, overflow, full, empty, 1'b0, count[9:0]}
  function automatic logic [MP_RES_W-1:0] mp_status_word(
    input logic       overflow,
    input logic       full,
    input logic       empty,
    input logic [9:0] count
  );
    return {50'b0, overflow, full, empty, 1'b0, count};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_rfifo_mem.sv
// ============================================================================
// Module   : mp_rfifo_mem
// Purpose  : DEPTH x W storage array for the result FIFO. Synchronous write,
//            asynchronous (combinational) read at the read pointer.
// Ports    : clk       - system clock
//            i_we      - write enable
//            i_wr_ptr  - write address
//            i_wr_data - write data
//            i_rd_ptr  - read address
//            o_rd_data - word stored at i_rd_ptr
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_rfifo_mem #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 64
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_wr_ptr,
  input  logic [W-1:0]  i_wr_data,
  input  logic [AW-1:0] i_rd_ptr,
  output logic [W-1:0]  o_rd_data
);

  // Storage carries no reset: the pointers/count define which entries are valid.
  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/mp_result_fifo.sv
// ============================================================================
// Module   : mp_result_fifo
// Purpose  : Buffers 64-bit ALU/multiplier results pushed by the pipeline over
//            a valid/ready handshake. The host pops results and reads status
//            through a slave register port; interrupt_out is raised while
//            results are pending.
// Config   : MP_RFIFO_THRESH_EN - adds THRESH register (offset 0x4) and makes
//            the interrupt fire when count >= THRESH.
// Ports    : clk, reset_n (async, active-low)
//            res_valid/res_data/res_ready - result push handshake
//            s_sel/s_wr/s_addr/s_din      - slave register access
//            s_dout                       - registered read data
//            interrupt_out                - registered interrupt request
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_result_fifo
  import mp_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 res_valid,
  input  logic [MP_RES_W-1:0]  res_data,
  output logic                 res_ready,
  input  logic                 s_sel,
  input  logic                 s_wr,
  input  logic [MP_BUS_AW-1:0] s_addr,
  input  logic [MP_BUS_DW-1:0] s_din,
  output logic [MP_RES_W-1:0]  s_dout,
  output logic                 interrupt_out
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                r_overflow;
  logic                r_int_en;
  logic [MP_RES_W-1:0] r_dout;
  logic                r_irq;

  logic                w_full;
  logic                w_empty;
  logic                w_rd;
  logic                w_wr;
  logic [3:0]          w_addr;
  logic                w_pop;
  logic                w_push;
  logic                w_flush;
  logic                w_ovf_set;
  logic                w_ovf_clr;
  logic                w_int_next;
  logic [MP_RES_W-1:0] w_head;
  logic [MP_RES_W-1:0] w_rd_data;
  logic [9:0]          w_count10;

  assign w_full    = (r_count == C_DEPTH);
  assign w_empty   = (r_count == '0);
  assign w_rd      = s_sel && !s_wr;
  assign w_wr      = s_sel && s_wr;
  assign w_addr    = s_addr[3:0];
  assign w_count10 = 10'(r_count);

  // Flush takes priority over a simultaneous push; the discarded push does
  // not count as an overflow.
  assign w_flush   = w_wr && (w_addr == MP_RF_CTRL) && s_din[0];
  assign w_ovf_clr = w_wr && (w_addr == MP_RF_CTRL) && s_din[1];
  assign w_pop     = w_rd && (w_addr == MP_RF_DATA) && !w_empty;
  assign w_push    = res_valid && !w_full && !w_flush;
  assign w_ovf_set = res_valid && w_full && !w_flush;

  assign res_ready     = !w_full;
  assign s_dout        = r_dout;
  assign interrupt_out = r_irq;

  mp_rfifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (MP_RES_W)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_push),
    .i_wr_ptr  (r_wr_ptr),
    .i_wr_data (res_data),
    .i_rd_ptr  (r_rd_ptr),
    .o_rd_data (w_head)
  );

`ifdef MP_RFIFO_THRESH_EN
  logic [AW:0] r_thresh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_thresh <= (AW+1)'(1);
    end else if (w_wr && (w_addr == MP_RF_THRESH)) begin
      r_thresh <= s_din[AW:0];
    end
  end

  assign w_int_next = r_int_en && (r_count >= r_thresh);
`else
  assign w_int_next = r_int_en && !w_empty;
`endif

  // Read data mux for the registered slave port
  always_comb begin
    w_rd_data = '0;
    case (w_addr)
      MP_RF_DATA:   w_rd_data = w_empty ? '0 : w_head;
      MP_RF_STATUS: w_rd_data = mp_status_word(r_overflow, w_full, w_empty, w_count10);
      MP_RF_INT_EN: w_rd_data = {{(MP_RES_W-1){1'b0}}, r_int_en};
`ifdef MP_RFIFO_THRESH_EN
      MP_RF_THRESH: w_rd_data = MP_RES_W'(r_thresh);
`endif
      default:      w_rd_data = '0;
    endcase
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Status/control registers, read data and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
      r_int_en   <= 1'b0;
      r_dout     <= '0;
      r_irq      <= 1'b0;
    end else begin
      // A new overflow event wins over a same-cycle clear so it is never lost
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (w_ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_wr && (w_addr == MP_RF_INT_EN)) begin
        r_int_en <= s_din[0];
      end
      if (w_rd) begin
        r_dout <= w_rd_data;
      end
      r_irq <= w_int_next;
    end
  end

  // Address and data bits outside the decoded range are intentionally ignored
  logic w_unused_bits;
  assign w_unused_bits = ^{s_addr[MP_BUS_AW-1:4], s_din[MP_BUS_DW-1:2]};

endmodule

`default_nettype wire

// File: tb/tb_mp_result_fifo.sv
// ============================================================================
// Module   : tb_mp_result_fifo
// Purpose  : Self-checking bench for mp_result_fifo with a queue scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mp_result_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic        res_valid;
  logic [63:0] res_data;
  logic        res_ready;
  logic        s_sel;
  logic        s_wr;
  logic [15:0] s_addr;
  logic [31:0] s_din;
  logic [63:0] s_dout;
  logic        interrupt_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        m_ovf;

  mp_result_fifo #(
    .DEPTH (DEPTH),
    .AW    (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .res_valid     (res_valid),
    .res_data      (res_data),
    .res_ready     (res_ready),
    .s_sel         (s_sel),
    .s_wr          (s_wr),
    .s_addr        (s_addr),
    .s_din         (s_din),
    .s_dout        (s_dout),
    .interrupt_out (interrupt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_status();
    int sz;
    sz = exp_q.size();
    return {50'b0, m_ovf, (sz == DEPTH), (sz == 0), 1'b0, 10'(sz)};
  endfunction

  task automatic push_word(input logic [63:0] d);
    check_eq("res_ready", 64'(res_ready), 64'(exp_q.size() < DEPTH));
    res_valid = 1'b1;
    res_data  = d;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
    else m_ovf = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    s_sel = 1'b1; s_wr = 1'b1; s_addr = 16'(a); s_din = d;
    tick();
    s_sel = 1'b0; s_wr = 1'b0;
    if (a == 4'h3) begin
      if (d[0]) exp_q.delete();
      if (d[1]) m_ovf = 1'b0;
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [63:0] d);
    s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'(a);
    tick();
    s_sel = 1'b0;
    d = s_dout;
  endtask

  task automatic read_data();
    logic [63:0] d;
    logic [63:0] e;
    e = 64'h0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    bus_read(4'h0, d);
    check_eq("data", d, e);
  endtask

  task automatic read_status(input string tag);
    logic [63:0] d;
    logic [63:0] e;
    e = exp_status();
    bus_read(4'h1, d);
    check_eq(tag, d, e);
  endtask

  // Push and DATA pop in the same cycle
  task automatic push_pop(input logic [63:0] d);
    int          sz;
    logic [63:0] e;
    sz = exp_q.size();
    e  = 64'h0;
    res_valid = 1'b1; res_data = d;
    s_sel = 1'b1; s_wr = 1'b0; s_addr = 16'h0;
    tick();
    res_valid = 1'b0; s_sel = 1'b0;
    if (sz > 0) e = exp_q.pop_front();
    if (sz < DEPTH) exp_q.push_back(d);
    else m_ovf = 1'b1;
    check_eq("push_pop_data", s_dout, e);
  endtask

  initial begin
    logic [63:0] d;
    reset_n = 1'b0; res_valid = 1'b0; res_data = '0;
    s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1. Reset state
    check_eq("rst_dout", s_dout, 64'h0);
    check_eq("rst_irq", 64'(interrupt_out), 64'h0);
    check_eq("rst_ready", 64'(res_ready), 64'h1);
    read_status("rst_status");
    check_eq("rst_status_const", s_dout, 64'h0000_0000_0000_0800);

    // 2. Basic ordering
    push_word(64'h1);
    push_word(64'h2);
    push_word(64'hFFFF_FFFF_0000_0003);
    read_status("status_3");
    repeat (3) read_data();
    read_status("status_empty");
    read_data();  // empty pop returns 0

    // 3. Overflow
    for (int i = 0; i < 9; i++) push_word(64'h100 + 64'(i));
    check_eq("full_ready", 64'(res_ready), 64'h0);
    read_status("status_ovf");
    bus_write(4'h3, 32'h2);
    read_status("status_ovf_clr");
    repeat (DEPTH) read_data();

    // 4. Push + pop at full and with wrap
    for (int i = 0; i < DEPTH; i++) push_word(64'h200 + 64'(i));
    push_pop(64'h2FF);  // full: push dropped
    read_status("status_pp_full");
    for (int i = 0; i < 4; i++) begin
      push_pop(64'h300 + 64'(i));
      read_status("status_pp_7");
    end
    repeat (7) read_data();
    bus_write(4'h3, 32'h2);
    push_pop(64'hABC);  // empty: returns 0, push accepted
    read_status("status_pp_empty");
    read_data();

    // Flush with simultaneous push
    push_word(64'h55);
    res_valid = 1'b1; res_data = 64'h66;
    bus_write(4'h3, 32'h1);
    res_valid = 1'b0;
    read_status("status_flush");

    // 5. Interrupt
    bus_write(4'h2, 32'h1);
    bus_read(4'h2, d);
    check_eq("int_en_rd", d, 64'h1);
    tick();
    check_eq("irq_idle", 64'(interrupt_out), 64'h0);
    push_word(64'h77);
    check_eq("irq_push_1", 64'(interrupt_out), 64'h0);
    tick();
    check_eq("irq_push_2", 64'(interrupt_out), 64'h1);
    read_data();
    check_eq("irq_pop_0", 64'(interrupt_out), 64'h1);
    tick();
    check_eq("irq_pop_1", 64'(interrupt_out), 64'h0);
`ifdef MP_RFIFO_THRESH_EN
    bus_write(4'h4, 32'h4);
    bus_read(4'h4, d);
    check_eq("thresh_rd", d, 64'h4);
    for (int i = 0; i < 3; i++) push_word(64'h400 + 64'(i));
    tick();
    check_eq("irq_th_3", 64'(interrupt_out), 64'h0);
    push_word(64'h403);
    tick();
    check_eq("irq_th_4", 64'(interrupt_out), 64'h1);
    bus_write(4'h4, 32'h1);
`else
    bus_read(4'h4, d);
    check_eq("unmapped_4", d, 64'h0);
`endif
    bus_read(4'h5, d);
    check_eq("unmapped_5", d, 64'h0);
    bus_read(4'h3, d);
    check_eq("ctrl_rd", d, 64'h0);
    bus_write(4'h3, 32'h1);

    // 6. Asynchronous reset mid-push with 5 entries
    for (int i = 0; i < 5; i++) push_word(64'h500 + 64'(i));
    tick();
    check_eq("irq_pre_rst", 64'(interrupt_out), 64'h1);
    read_status("status_5");
    res_valid = 1'b1; res_data = 64'h5FF;
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_dout", s_dout, 64'h0);
    check_eq("arst_irq", 64'(interrupt_out), 64'h0);
    check_eq("arst_ready", 64'(res_ready), 64'h1);
    tick();
    res_valid = 1'b0;
    reset_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    tick();
    read_status("status_post_rst");
    bus_read(4'h2, d);
    check_eq("int_en_post_rst", d, 64'h0);
    check_eq("irq_post_rst", 64'(interrupt_out), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
